// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: opcodes and FSM state shared by the SPI RAM controller files
package spi_ram_pkg;
  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;
  typedef enum logic {IDLE, SEND} state_t;
endpackage

// File: rtl/spi_ram_array.sv
// spi_ram_array: single write port, registered read port that only updates when re is set
module spi_ram_array #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  always_ff @(posedge clk)
    if (rst) o_rdata <= '0;
    else if (i_re) o_rdata <= r_mem[i_raddr];
endmodule

// File: rtl/spi_ram_burst.sv
// spi_ram_burst: command decoder, write/read pointers and burst-read FSM
import spi_ram_pkg::*;
module spi_ram_burst #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 4,
  parameter bit AUTO_INC   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH+1:0] din,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  tx_valid,
  input  logic                  tx_ready
);
  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr, w_rd_inc, w_raddr;
  logic [LEN_WIDTH-1:0]  r_cnt;
  logic [1:0]            w_op;
  logic [DATA_WIDTH-1:0] w_pay;
  logic                  w_acc, w_ack, w_last, w_load;
  assign w_op     = din[DATA_WIDTH+1:DATA_WIDTH];
  assign w_pay    = din[DATA_WIDTH-1:0];
  assign w_acc    = rx_valid && rx_ready;
  assign w_ack    = tx_valid && tx_ready;
  assign w_last   = r_cnt == '0;
  assign w_rd_inc = AUTO_INC ? r_rd_ptr + 1'b1 : r_rd_ptr;
  // the array read is issued at the same edge the word must appear, so on an ack it fetches the next address
  assign w_load   = (w_acc && w_op == OP_RD_DATA) || (w_ack && !w_last);
  assign w_raddr  = w_ack ? w_rd_inc : r_rd_ptr;
  spi_ram_array #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_array (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_acc && w_op == OP_WR_DATA),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_pay),
    .i_re    (w_load),
    .i_raddr (w_raddr),
    .o_rdata (dout)
  );
  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else r_state <= w_state_nxt;
  always_comb
    w_state_nxt = (r_state == IDLE) ? ((w_acc && w_op == OP_RD_DATA) ? SEND : IDLE)
                                    : ((w_ack && w_last) ? IDLE : SEND);
  always_comb begin
    rx_ready = r_state == IDLE;
    tx_valid = r_state == SEND;
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_acc && w_op == OP_WR_ADDR) r_wr_ptr <= w_pay[ADDR_WIDTH-1:0];
      else if (w_acc && w_op == OP_WR_DATA && AUTO_INC) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_acc && w_op == OP_RD_ADDR) r_rd_ptr <= w_pay[ADDR_WIDTH-1:0];
      else if (w_ack) r_rd_ptr <= w_rd_inc;
      if (w_acc && w_op == OP_RD_DATA) r_cnt <= w_pay[LEN_WIDTH-1:0];
      else if (w_ack && !w_last) r_cnt <= r_cnt - 1'b1;
    end
endmodule

// File: tb/tb_spi_ram_burst.sv
// tb_spi_ram_burst: directed checks of an auto-increment and a static-pointer controller
module tb_spi_ram_burst;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] din = '0;
  logic       rv_a = 1'b0, rv_b = 1'b0, tx_ready = 1'b0;
  logic       rr_a, rr_b, tv_a, tv_b;
  logic [7:0] dout_a, dout_b;
  int         n_vec = 0, n_err = 0, k;
  always #5 clk = ~clk;
  spi_ram_burst #(.AUTO_INC(1'b1)) u_a (
    .clk(clk), .rst(rst), .din(din), .rx_valid(rv_a), .rx_ready(rr_a),
    .dout(dout_a), .tx_valid(tv_a), .tx_ready(tx_ready)
  );
  spi_ram_burst #(.AUTO_INC(1'b0)) u_b (
    .clk(clk), .rst(rst), .din(din), .rx_valid(rv_b), .rx_ready(rr_b),
    .dout(dout_b), .tx_valid(tv_b), .tx_ready(tx_ready)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cmd(input bit b, input logic [1:0] op, input logic [7:0] p);
    din = {op, p};
    if (b) rv_b = 1'b1;
    else rv_a = 1'b1;
    @(posedge clk);
    #1;
    rv_a = 1'b0;
    rv_b = 1'b0;
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  initial begin
    step();
    step();
    rst = 1'b0;
    chk("rst_dout", dout_a, 0);
    chk("rst_tv", tv_a, 0);
    chk("rst_rr", rr_a, 1);
    chk("rst_wp", u_a.r_wr_ptr, 0);
    chk("rst_rp", u_a.r_rd_ptr, 0);
    // single read
    cmd(0, 2'b00, 8'h10);
    cmd(0, 2'b01, 8'hA5);
    cmd(0, 2'b10, 8'h10);
    cmd(0, 2'b11, 8'h00);
    chk("s_tv", tv_a, 1);
    chk("s_rr", rr_a, 0);
    chk("s_dout", dout_a, 8'hA5);
    tx_ready = 1'b1;
    step();
    chk("s_tv_end", tv_a, 0);
    chk("s_rr_end", rr_a, 1);
    chk("s_rp", u_a.r_rd_ptr, 8'h11);
    chk("s_dout_hold", dout_a, 8'hA5);
    tx_ready = 1'b0;
    // burst write then burst read at full rate
    cmd(0, 2'b00, 8'h20);
    for (int i = 1; i <= 4; i++) cmd(0, 2'b01, 8'(i));
    chk("bw_wp", u_a.r_wr_ptr, 8'h24);
    cmd(0, 2'b10, 8'h20);
    tx_ready = 1'b1;
    cmd(0, 2'b11, 8'h03);
    chk("b_w1", dout_a, 1);
    for (int i = 2; i <= 4; i++) begin
      step();
      chk("b_tv", tv_a, 1);
      chk("b_w", dout_a, i);
    end
    step();
    chk("b_done", tv_a, 0);
    chk("b_rp", u_a.r_rd_ptr, 8'h24);
    tx_ready = 1'b0;
    // back-pressure with tx_ready pattern 1,0,0,1,...
    cmd(0, 2'b10, 8'h20);
    cmd(0, 2'b11, 8'h03);
    k = 1;
    for (int c = 0; c < 20 && k <= 4; c++) begin
      tx_ready = (c % 3 == 0);
      chk("bp_tv", tv_a, 1);
      chk("bp_dout", dout_a, k);
      step();
      if (tx_ready) k++;
    end
    chk("bp_count", k, 5);
    chk("bp_done", tv_a, 0);
    tx_ready = 1'b0;
    // wrap-around of both pointers
    cmd(0, 2'b00, 8'hFF);
    cmd(0, 2'b01, 8'hAA);
    cmd(0, 2'b01, 8'hBB);
    chk("wr_wp", u_a.r_wr_ptr, 8'h01);
    cmd(0, 2'b10, 8'hFF);
    tx_ready = 1'b1;
    cmd(0, 2'b11, 8'h01);
    chk("wr_w1", dout_a, 8'hAA);
    step();
    chk("wr_w2", dout_a, 8'hBB);
    step();
    chk("wr_done", tv_a, 0);
    chk("wr_rp", u_a.r_rd_ptr, 8'h01);
    tx_ready = 1'b0;
    // command dropped during SEND, then reset mid-burst
    cmd(0, 2'b00, 8'h21);
    cmd(0, 2'b10, 8'h20);
    cmd(0, 2'b11, 8'h05);
    cmd(0, 2'b01, 8'h77);
    chk("dr_wp", u_a.r_wr_ptr, 8'h21);
    chk("dr_tv", tv_a, 1);
    chk("dr_dout", dout_a, 1);
    tx_ready = 1'b1;
    step();
    chk("mr_w2", dout_a, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    tx_ready = 1'b0;
    chk("mr_tv", tv_a, 0);
    chk("mr_rr", rr_a, 1);
    chk("mr_wp", u_a.r_wr_ptr, 0);
    chk("mr_rp", u_a.r_rd_ptr, 0);
    step();
    chk("mr_idle", tv_a, 0);
    cmd(0, 2'b10, 8'h20);
    tx_ready = 1'b1;
    cmd(0, 2'b11, 8'h03);
    for (int i = 1; i <= 4; i++) begin
      chk("mi_w", dout_a, i);
      step();
    end
    chk("mi_done", tv_a, 0);
    tx_ready = 1'b0;
    // static pointers: writes overwrite, burst repeats one word
    cmd(1, 2'b00, 8'h30);
    cmd(1, 2'b01, 8'h5C);
    cmd(1, 2'b01, 8'h6D);
    chk("st_wp", u_b.r_wr_ptr, 8'h30);
    cmd(1, 2'b10, 8'h30);
    tx_ready = 1'b1;
    cmd(1, 2'b11, 8'h02);
    for (int i = 0; i < 3; i++) begin
      chk("st_tv", tv_b, 1);
      chk("st_w", dout_b, 8'h6D);
      step();
    end
    chk("st_done", tv_b, 0);
    chk("st_rp", u_b.r_rd_ptr, 8'h30);
    chk("st_a_idle", tv_a, 0);
    tx_ready = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
